// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM states, address width and the IF/ID bundle
// consumed by decode.
package cpu_pkg;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 8;

  // Opcodes whose high nibble matches this carry a trailing immediate byte
  localparam logic [3:0] IMM_OPCODE_HI = 4'hC;

  localparam logic [ADDR_W-1:0] RESET_VEC_ADDR = 8'h00;

  typedef enum logic [1:0] {
    VEC  = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] instr;
    logic [DATA_W-1:0] imm;
    logic              imm_en;
    logic [ADDR_W-1:0] pc_next;
  } ifid_t;

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: bubble clears only valid, load captures a new
// instruction, otherwise every field holds.
module ifid_reg
  import cpu_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  load,
  input  logic  bubble,
  input  ifid_t d,
  output ifid_t q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (bubble) begin
      q.valid <= 1'b0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/instr_fetch_stage.sv
// Fetch stage: owns the PC, loads it from the reset vector, follows branch
// redirects, stalls and halt, and feeds the IF/ID register.
module instr_fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [cpu_pkg::ADDR_W-1:0] RESET_VEC_ADDR = cpu_pkg::RESET_VEC_ADDR,
  parameter int unsigned                ADDR_W         = cpu_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] addr_instr,
  input  logic [7:0]        instr_in,
  input  logic [7:0]        imm_in,
  input  logic              imm_en_in,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              halt_req,
  output logic              ifid_valid,
  output logic [7:0]        ifid_instr,
  output logic [7:0]        ifid_imm,
  output logic              ifid_imm_en,
  output logic [ADDR_W-1:0] ifid_pc_next,
  output logic              halted
);

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_inc;
  logic              run;
  logic              load;
  logic              bubble;
  ifid_t             ifid_d;
  ifid_t             ifid_q;

  // Address and IF/ID controls; priority is branch > halt > stall > fetch
  always_comb begin
    addr_instr = (state == VEC) ? RESET_VEC_ADDR : pc;
    pc_inc     = pc + (imm_en_in ? ADDR_W'(2) : ADDR_W'(1));
    run        = (state == RUN);
    bubble     = run && (branch_taken || halt_req);
    load       = run && !branch_taken && !halt_req && !stall;

    ifid_d         = '0;
    ifid_d.valid   = 1'b1;
    ifid_d.instr   = instr_in;
    ifid_d.imm     = imm_en_in ? imm_in : 8'h00;
    ifid_d.imm_en  = imm_en_in;
    ifid_d.pc_next = pc_inc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= VEC;
      pc     <= '0;
      halted <= 1'b0;
    end else begin
      case (state)
        VEC: begin
          pc    <= ADDR_W'(instr_in);
          state <= RUN;
        end
        RUN: begin
          if (branch_taken) begin
            pc <= branch_target;
          end else if (halt_req) begin
            state  <= HALT;
            halted <= 1'b1;
          end else if (!stall) begin
            pc <= pc_inc;
          end
        end
        HALT: begin
          halted <= 1'b1;
        end
        default: begin
          state <= VEC;
        end
      endcase
    end
  end

  ifid_reg u_ifid_reg (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .bubble (bubble),
    .d      (ifid_d),
    .q      (ifid_q)
  );

  assign ifid_valid   = ifid_q.valid;
  assign ifid_instr   = ifid_q.instr;
  assign ifid_imm     = ifid_q.imm;
  assign ifid_imm_en  = ifid_q.imm_en;
  assign ifid_pc_next = ifid_q.pc_next;

endmodule

// File: doc/instr_fetch_stage.md
Name: instr_fetch_stage

Overview:
- Fetch stage that sits directly upstream of the unified 256-byte memory.
- Owns the program counter (PC) and drives the memory's instruction address.
- Captures the returned opcode byte and optional immediate byte into the IF/ID pipeline register for decode.
- Handles reset-vector load, stalls, branch redirects and halt.

Parameters:
- RESET_VEC_ADDR, 8'h00, memory address whose byte is loaded into PC after reset.
- ADDR_W, 8, PC/address width; all PC arithmetic is modulo 2^ADDR_W.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- addr_instr  output  8  instruction address presented to memory
- instr_in  input  8  opcode byte returned combinationally by memory
- imm_in  input  8  byte at addr_instr+1 returned by memory
- imm_en_in  input  1  memory flag: current opcode carries an immediate
- stall  input  1  hazard unit: hold PC and IF/ID
- branch_taken  input  1  execute stage: redirect fetch
- branch_target  input  8  redirect address
- halt_req  input  1  decode saw HLT: stop fetching
- ifid_valid  output  1  IF/ID holds a real instruction
- ifid_instr  output  8  latched opcode
- ifid_imm  output  8  latched immediate (0 if none)
- ifid_imm_en  output  1  latched immediate flag
- ifid_pc_next  output  8  address following the latched instruction (for CALL/return)
- halted  output  1  high in HALT state

Behaviour:
- Clock is clk; reset is rst, synchronous and active-high. All state changes occur on the rising edge of clk.
- States: VEC, RUN, HALT.
- Reset, sampled at the edge, has top priority:
  - state<=VEC, pc<=0.
  - ifid_valid<=0, ifid_instr<=0, ifid_imm<=0, ifid_imm_en<=0, ifid_pc_next<=0, halted<=0.
  - Reset mid-operation discards everything, including an in-flight redirect.
- VEC:
  - addr_instr=RESET_VEC_ADDR.
  - Next edge: pc<=instr_in, state<=RUN. ifid_valid stays 0.
  - stall, branch_taken and halt_req are ignored.
  - Net effect: the first valid instruction appears in IF/ID 2 cycles after rst deasserts.
- RUN: addr_instr=pc (combinational from the PC register). Priority is branch_taken > halt_req > stall > normal.
  - branch_taken: pc<=branch_target, ifid_valid<=0 (bubble). Other IF/ID fields are don't-care but must hold their previous values. The redirect wins even when stall=1.
  - halt_req: state<=HALT, ifid_valid<=0, pc holds.
  - stall: pc and every IF/ID field hold unchanged, including ifid_valid.
  - normal:
    - len = imm_en_in ? 2 : 1.
    - ifid_instr<=instr_in, ifid_imm_en<=imm_en_in, ifid_imm<=imm_en_in ? imm_in : 0.
    - ifid_pc_next<=pc+len, ifid_valid<=1, pc<=pc+len.
- HALT:
  - halted=1, ifid_valid=0, pc frozen, addr_instr=pc.
  - Exit only via rst; branch_taken is ignored.
- Wrap-around:
  - pc=8'hFF with a 1-byte instruction gives pc=8'h00.
  - pc=8'hFF with a 2-byte instruction gives pc=8'h01. The immediate comes from address 8'h00; the memory's +1 wraps in 8 bits.
- Latency: PC to IF/ID is 1 cycle. Throughput is 1 instruction per non-stalled cycle.
- No write-port interaction. Self-modifying writes are seen on the next fetch of that address.

Decomposition:
- Shared package cpu_pkg:
  - state enum {VEC, RUN, HALT}.
  - IMM_OPCODE_HI = 4'hC, RESET_VEC_ADDR default, ADDR_W.
  - IF/ID bundle layout (valid, instr, imm, imm_en, pc_next), for reuse by decode.
- One natural sub-module, ifid_reg: IF/ID pipeline register with load/hold/bubble controls and synchronous reset.
- The FSM and PC logic stay in the top level.

Test Plan:
- Reset vector: mem[0]=8'h10, mem[0x10]=8'h21, hold rst 3 cycles then release -> addr_instr=0 in cycle 1; pc=0x10 in cycle 2; ifid_valid=1 with ifid_instr=8'h21 and ifid_pc_next=0x11 at edge 3.
- Mixed lengths: mem[0x10]=8'hC5, mem[0x11]=8'h7A, mem[0x12]=8'h21 -> first IF/ID gives imm_en=1, imm=8'h7A, pc_next=0x12; next IF/ID gives instr=8'h21, imm=0, pc_next=0x13.
- Stall then redirect: stall=1 for 2 cycles -> pc and IF/ID are unchanged. Then stall=1 with branch_taken=1, target=0x40 -> pc=0x40, ifid_valid=0; next cycle IF/ID holds mem[0x40].
- Wrap: branch to 0xFF with mem[0xFF]=8'hC0, mem[0x00]=8'h55 -> ifid_imm=8'h55, ifid_pc_next=0x01, pc=0x01.
- Halt: assert halt_req in RUN -> halted=1, ifid_valid=0, pc frozen for 10 cycles despite branch_taken pulses. rst then returns to VEC.
- Reset mid-stream: rst asserted in the same cycle as branch_taken -> all outputs 0 and state VEC; the redirect is not applied.
